// File: rtl/lcd_pkg.sv
// lcd_pkg: LCD command bytes, controller state encoding and small decode helpers.
package lcd_pkg;

    localparam logic [7:0] CMD_FSET    = 8'h38;
    localparam logic [7:0] CMD_DISP_ON = 8'h0C;
    localparam logic [7:0] CMD_ENTRY   = 8'h06;
    localparam logic [7:0] CMD_CLEAR   = 8'h01;
    localparam logic [7:0] DDRAM_ROW1  = 8'h80;
    localparam logic [7:0] DDRAM_ROW2  = 8'hC0;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    // Declaration order is the forward sequence; only ROW2 loops back to IDLE.
    typedef enum logic [3:0] {
        S_PWRUP, S_FSET, S_DISP, S_ENTRY, S_CLEAR,
        S_IDLE, S_ADDR1, S_ROW1, S_ADDR2, S_ROW2
    } state_e;

    function automatic logic is_row(state_e s);
        return s == S_ROW1 || s == S_ROW2;
    endfunction

    function automatic logic [7:0] cmd_byte(state_e s);
        return s == S_FSET  ? CMD_FSET    :
               s == S_DISP  ? CMD_DISP_ON :
               s == S_ENTRY ? CMD_ENTRY   :
               s == S_CLEAR ? CMD_CLEAR   :
               s == S_ADDR1 ? DDRAM_ROW1  : DDRAM_ROW2;
    endfunction

endpackage

// File: rtl/lcd_slot_timer.sv
// lcd_slot_timer: divides clk into bus slots of 2*CLK_DIV cycles.
//   clk, rst (sync, active-low) in; slot_end high on the last cycle of a slot,
//   e_rise high on the cycle before the E-high half of a slot.
module lcd_slot_timer #(
    parameter int CLK_DIV = 5
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end,
    output logic e_rise
);

    localparam int W = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

    logic [W-1:0] cnt_q, cnt_d;
    logic         phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q == LAST ? '0 : cnt_q + 1'b1;
        phase_d = cnt_q == LAST ? ~phase_q : phase_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign slot_end = phase_q && cnt_q == LAST;
    assign e_rise   = !phase_q && cnt_q == LAST;

endmodule

// File: rtl/lcd_refresh_ctrl.sv
// lcd_refresh_ctrl: HD44780 init sequencer, 32-byte shadow frame buffer and refresh engine.
//   clk, rst (sync, active-low) in.
//   Host port: wr_req/wr_line/wr_col/wr_char in, wr_ack out (one-cycle commit pulse).
//   ready out: init done. LCD pins: lcd_e, lcd_rs, lcd_rw, lcd_data[7:0] out.
module lcd_refresh_ctrl
    import lcd_pkg::*;
#(
    parameter int CLK_DIV = 5,
    parameter int T_PWRUP = 70,
    parameter int T_CMD   = 30,
    parameter int T_CLEAR = 200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_req,
    input  logic       wr_line,
    input  logic [3:0] wr_col,
    input  logic [7:0] wr_char,
    output logic       wr_ack,
    output logic       ready,
    output logic       lcd_e,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic [7:0] lcd_data
);

    state_e     state_q, state_d;
    logic [7:0] wait_q, wait_d, limit;
    logic [3:0] col_q, col_d;
    logic       dirty_q, dirty_d, ack_q, ack_d, ready_q, ready_d;
    logic       strobe_q, strobe_d, e_q, e_d, rs_q, rs_d, rw_q, rw_d;
    logic [7:0] data_q, data_d;
    logic [7:0] buf_q [32];
    logic [7:0] buf_d [32];
    logic       slot_end, e_rise, accept, done;

    lcd_slot_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .slot_end (slot_end),
        .e_rise   (e_rise)
    );

    // wait_q counts slots already spent in a state; the strobed slot of a
    // command is its first, so PWRUP (no strobe) stops one slot earlier.
    always_comb begin
        limit = state_q == S_PWRUP ? 8'(T_PWRUP - 1) :
                state_q == S_CLEAR ? 8'(T_CLEAR)     :
                (state_q == S_FSET || state_q == S_DISP || state_q == S_ENTRY) ? 8'(T_CMD) : 8'd0;
        done = is_row(state_q) ? col_q == 4'd15 : state_q == S_IDLE ? dirty_q : wait_q == limit;
        state_d = state_q;
        wait_d  = wait_q;
        col_d   = col_q;
        if (slot_end) begin
            state_d = !done ? state_q : state_q == S_ROW2 ? S_IDLE : state_e'(state_q + 4'd1);
            wait_d  = done ? 8'd0 : wait_q + 8'd1;
            col_d   = is_row(state_q) ? col_q + 4'd1 : col_q;
        end
    end

    // A host write beats the dirty clear of an IDLE->ADDR1 hand-off in the same cycle.
    always_comb begin
        accept  = wr_req && !ack_q;
        ack_d   = accept;
        buf_d   = buf_q;
        if (accept) buf_d[{wr_line, wr_col}] = wr_char;
        dirty_d = accept | (dirty_q & ~(slot_end && state_q == S_IDLE));
        ready_d = ready_q | (state_d == S_IDLE);
    end

    // Bus fields load at the slot boundary from the pre-write buffer (read-before-write).
    always_comb begin
        strobe_d = strobe_q;
        rs_d     = rs_q;
        rw_d     = rw_q;
        data_d   = data_q;
        e_d      = slot_end ? 1'b0 : e_rise ? strobe_q : e_q;
        if (slot_end) begin
            strobe_d = is_row(state_d) || (wait_d == 8'd0 && state_d != S_PWRUP && state_d != S_IDLE);
            rs_d     = is_row(state_d);
            rw_d     = !strobe_d;
            data_d   = !strobe_d ? 8'd0 : is_row(state_d) ? buf_q[{state_d == S_ROW2, col_d}] : cmd_byte(state_d);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= S_PWRUP;
            wait_q   <= 8'd0;
            col_q    <= 4'd0;
            dirty_q  <= 1'b1;
            ack_q    <= 1'b0;
            ready_q  <= 1'b0;
            strobe_q <= 1'b0;
            e_q      <= 1'b0;
            rs_q     <= 1'b0;
            rw_q     <= 1'b1;
            data_q   <= 8'd0;
            for (int i = 0; i < 32; i++) buf_q[i] <= ASCII_SPACE;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            col_q    <= col_d;
            dirty_q  <= dirty_d;
            ack_q    <= ack_d;
            ready_q  <= ready_d;
            strobe_q <= strobe_d;
            e_q      <= e_d;
            rs_q     <= rs_d;
            rw_q     <= rw_d;
            data_q   <= data_d;
            buf_q    <= buf_d;
        end
    end

    assign wr_ack   = ack_q;
    assign ready    = ready_q;
    assign lcd_e    = e_q;
    assign lcd_rs   = rs_q;
    assign lcd_rw   = rw_q;
    assign lcd_data = data_q;

endmodule

// File: tb/tb_lcd_refresh_ctrl.sv
// tb_lcd_refresh_ctrl: self-checking bench for lcd_refresh_ctrl against a panel-level model.
module tb_lcd_refresh_ctrl;

    localparam int CLK_DIV = 5;
    localparam int T_PWRUP = 70;
    localparam int T_CMD   = 30;
    localparam int T_CLEAR = 200;
    localparam int SLOT    = 2 * CLK_DIV;

    logic       clk = 1'b0, rst = 1'b0, wr_req = 1'b0, wr_line = 1'b0;
    logic [3:0] wr_col = 4'd0;
    logic [7:0] wr_char = 8'd0;
    logic       wr_ack, ready, lcd_e, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;

    lcd_refresh_ctrl #(.CLK_DIV(CLK_DIV), .T_PWRUP(T_PWRUP), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)) dut (
        .clk(clk), .rst(rst), .wr_req(wr_req), .wr_line(wr_line), .wr_col(wr_col), .wr_char(wr_char),
        .wr_ack(wr_ack), .ready(ready), .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_data(lcd_data)
    );

    always #5 clk = ~clk;

    typedef struct { logic rs; logic [7:0] d; int cyc; } strobe_t;
    typedef struct { logic rs; logic [7:0] d; int slot; } init_vec_t;

    int         n_chk = 0, n_fail = 0, cyc = 0, ready_cyc = -1, paddr = 0;
    strobe_t    sq[$];
    logic [7:0] panel [32];
    logic [7:0] mbuf  [32];
    logic       e_prev = 1'b0, rdy_prev = 1'b0, rs_at = 1'b0;
    logic [7:0] d_at = 8'd0;

    // cyc = cycles since the last reset edge, so slot s cycle k reads as 10*s+k at negedge.
    always @(posedge clk) cyc <= !rst ? 0 : cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, want, $time);
        end
    endfunction

    // Panel model: a write-only HD44780 DDRAM with an auto-incrementing address.
    always @(negedge clk) begin
        if (lcd_e && !e_prev) begin
            sq.push_back('{lcd_rs, lcd_data, cyc});
            rs_at = lcd_rs;
            d_at  = lcd_data;
            if (lcd_rs) begin
                panel[paddr % 32] = lcd_data;
                paddr++;
            end else if (lcd_data[7]) paddr = (lcd_data[6] ? 16 : 0) + int'(lcd_data[3:0]);
            else if (lcd_data == 8'h01) begin
                for (int i = 0; i < 32; i++) panel[i] = 8'h20;
                paddr = 0;
            end
        end
        if (lcd_e) begin
            chk("e_in_high_half", 32'(cyc % SLOT >= CLK_DIV), 1);
            chk("rw_during_e", 32'(lcd_rw), 0);
            chk("bus_stable_during_e", {lcd_rs, lcd_data}, {rs_at, d_at});
        end
        if (ready && !rdy_prev) ready_cyc = cyc;
        e_prev   = lcd_e;
        rdy_prev = ready;
    end

    task automatic do_reset(int n);
        rst    = 1'b0;
        wr_req = 1'b0;
        repeat (n) @(negedge clk);
        chk("rst_e", 32'(lcd_e), 0);
        chk("rst_rs", 32'(lcd_rs), 0);
        chk("rst_rw", 32'(lcd_rw), 1);
        chk("rst_data", 32'(lcd_data), 0);
        chk("rst_ack", 32'(wr_ack), 0);
        chk("rst_ready", 32'(ready), 0);
        for (int i = 0; i < 32; i++) mbuf[i] = 8'h20;
        ready_cyc = -1;
        rst = 1'b1;
    endtask

    task automatic host_write(logic line, logic [3:0] col, logic [7:0] ch);
        chk("ack_idle", 32'(wr_ack), 0);
        wr_line = line;
        wr_col  = col;
        wr_char = ch;
        wr_req  = 1'b1;
        @(negedge clk);
        chk("ack_rise", 32'(wr_ack), 1);
        wr_req = 1'b0;
        mbuf[{line, col}] = ch;
        @(negedge clk);
        chk("ack_fall", 32'(wr_ack), 0);
    endtask

    task automatic wait_strobes(string name, int n, int budget);
        int t = 0;
        while (sq.size() < n && t < budget) begin
            @(negedge clk);
            t++;
        end
        chk({name, "_strobe_timeout"}, 32'(sq.size() >= n), 1);
    endtask

    task automatic wait_quiet(string name);
        int t = 0, idle = 0, last = sq.size();
        while (idle < 50 * SLOT && t < 20000) begin
            @(negedge clk);
            t++;
            if (sq.size() != last) begin
                last = sq.size();
                idle = 0;
            end else idle++;
        end
        chk({name, "_quiet_timeout"}, 32'(idle >= 50 * SLOT), 1);
    endtask

    // A refresh pass: 80, row-1 bytes, C0, row-2 bytes, in 34 back-to-back slots.
    task automatic check_pass(string name, int start, logic [7:0] want [32]);
        logic       e_rs;
        logic [7:0] e_d;
        if (start < 0 || sq.size() < start + 34) begin
            chk({name, "_pass_len"}, 32'(sq.size()), 32'(start + 34));
            return;
        end
        for (int i = 0; i < 34; i++) begin
            e_rs = !(i == 0 || i == 17);
            e_d  = i == 0 ? 8'h80 : i == 17 ? 8'hC0 : i < 17 ? want[i-1] : want[i-2];
            chk($sformatf("%s[%0d]", name, i), {sq[start+i].rs, sq[start+i].d}, {e_rs, e_d});
            if (i > 0) chk($sformatf("%s_gap[%0d]", name, i), 32'(sq[start+i].cyc - sq[start+i-1].cyc), SLOT);
        end
    endtask

    initial begin
        init_vec_t  init_tab [5];
        logic [7:0] cmds [4];
        logic [7:0] snap [32];
        int         m;
        cmds = '{8'h38, 8'h0C, 8'h06, 8'h01};
        for (int k = 0; k < 4; k++) init_tab[k] = '{1'b0, cmds[k], T_PWRUP + k * (T_CMD + 1)};
        init_tab[4] = '{1'b0, 8'h80, T_PWRUP + 3 * (T_CMD + 1) + 1 + T_CLEAR + 1};

        @(negedge clk);
        do_reset(3);
        m = sq.size();
        wait_strobes("init", m + 5, 5000);
        for (int k = 0; k < 5; k++) begin
            if (sq.size() > m + k) begin
                chk($sformatf("init_cmd[%0d]", k), {sq[m+k].rs, sq[m+k].d}, {init_tab[k].rs, init_tab[k].d});
                chk($sformatf("init_slot[%0d]", k), 32'(sq[m+k].cyc), 32'(init_tab[k].slot * SLOT + CLK_DIV));
            end
        end
        chk("ready_rise_cycle", 32'(ready_cyc), 32'((T_PWRUP + 3 * (T_CMD + 1) + 1 + T_CLEAR) * SLOT));
        wait_quiet("pass0");
        check_pass("pass0", m + 4, mbuf);
        chk("pass0_single", 32'(sq.size()), 32'(m + 38));
        chk("ready_held", 32'(ready), 1);

        m = sq.size();
        host_write(1'b0, 4'd0, 8'h48);
        host_write(1'b1, 4'd15, 8'h64);
        wait_quiet("hd");
        check_pass("hd", m, mbuf);
        if (sq.size() >= m + 34) begin
            chk("hd_byte1", 32'(sq[m+1].d), 8'h48);
            chk("hd_byte33", 32'(sq[m+33].d), 8'h64);
        end

        m = sq.size();
        host_write(1'b0, 4'd2, 8'h41);
        snap = mbuf;
        wait_strobes("row2", m + 18, 1000);
        host_write(1'b0, 4'd5, 8'h58);
        wait_quiet("row2");
        check_pass("row2_old", m, snap);
        check_pass("row2_new", m + 34, mbuf);
        chk("row2_two_passes", 32'(sq.size()), 32'(m + 68));

        m = sq.size();
        host_write(1'b0, 4'd9, 8'h51);
        wait_strobes("same", m + 21, 1000);
        for (int t = 0; t < SLOT && cyc % SLOT != SLOT - 1; t++) @(negedge clk);
        snap = mbuf;
        host_write(1'b1, 4'd3, 8'h5A);
        wait_quiet("same");
        check_pass("same_old", m, snap);
        check_pass("same_new", m + 34, mbuf);
        chk("same_two_passes", 32'(sq.size()), 32'(m + 68));

        for (int n = 0; n < 30; n++) begin
            repeat ($urandom_range(0, 300)) @(negedge clk);
            host_write(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom_range(33, 126)));
        end
        wait_quiet("rand");
        for (int i = 0; i < 32; i++) chk($sformatf("rand_panel[%0d]", i), 32'(panel[i]), 32'(mbuf[i]));
        check_pass("rand_last", sq.size() - 34, mbuf);

        m = sq.size();
        host_write(1'b0, 4'd7, 8'h52);
        wait_strobes("midrst", m + 4, 1000);
        do_reset(1);
        m = sq.size();
        wait_strobes("rst_init", m + 5, 5000);
        if (sq.size() > m) begin
            chk("rst_first_cmd", {sq[m].rs, sq[m].d}, {1'b0, 8'h38});
            chk("rst_first_slot", 32'(sq[m].cyc), 32'(T_PWRUP * SLOT + CLK_DIV));
        end
        wait_quiet("rst_pass");
        check_pass("rst_pass", m + 4, mbuf);
        chk("rst_single_pass", 32'(sq.size()), 32'(m + 38));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, %0d failures so far", n_fail);
        $fatal(1, "watchdog");
    end

endmodule
